im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_pkg.sv | 11 +
 rtl/im_loader_if.sv | 11 +
 rtl/im_loader_word_asm.sv | 22 ++
 rtl/im_loader.sv | 95 +++++++++
 tb/tb_im_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: loader FSM state encodings and stream framing constants
package im_loader_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHK    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam int HDR_LEN = 2;
endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: byte receive handshake plus instruction-memory write port
interface im_loader_if #(parameter int ADDR_W = 16);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0] wr_data;
  modport master(input rx_data, rx_valid, output rx_ready, wr_en, wr_addr, wr_data);
  modport slave(output rx_data, rx_valid, input rx_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/im_loader_word_asm.sv
// im_loader_word_asm: shifts bytes MSB-first into a word, flags the 4th byte
module im_loader_word_asm (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic en,
  input  logic [7:0] din,
  output logic [31:0] word,
  output logic last
);
  logic [1:0] cnt;
  assign last = en && cnt == 2'd3;
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) begin
      word <= '0;
      cnt <= '0;
    end else if (clr) cnt <= '0;
    else if (en) begin
      word <= {word[23:0], din};
      cnt <= cnt + 2'd1;
    end
endmodule

// File: rtl/im_loader.sv
// im_loader: streams a length-prefixed byte image into instruction memory.
// Optional trailing XOR checksum byte enabled by IM_LOADER_CHECKSUM_EN.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 65536
) (
  input  logic clk,
  input  logic rst_f,
  input  logic start,
  im_loader_if.master bus,
  output logic cpu_rst_f,
  output logic busy,
  output logic done,
  output logic err,
  output logic [ADDR_W:0] word_cnt
);
  logic [2:0] state;
  logic [7:0] len_hi;
  logic [15:0] len;
  logic [15:0] n_rx;
  logic acc, last, in_chk;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_END = S_CHK;
  logic [7:0] csum;
  assign in_chk = state == S_CHK;
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) csum <= '0;
    else if (state == S_IDLE) csum <= '0;
    else if (acc && !in_chk) csum <= csum ^ bus.rx_data;
`else
  localparam logic [2:0] S_END = S_DONE;
  assign in_chk = 1'b0;
`endif
  assign n_rx = {len_hi, bus.rx_data};
  assign acc = bus.rx_valid && bus.rx_ready;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign bus.wr_en = state == S_WRITE;
  assign bus.rx_ready = state == S_LEN_HI || state == S_LEN_LO || state == S_DATA || in_chk;
  im_loader_word_asm word_asm (
    .clk(clk),
    .rst_f(rst_f),
    .clr(state == S_IDLE),
    .en(acc && state == S_DATA),
    .din(bus.rx_data),
    .word(bus.wr_data),
    .last(last)
  );
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) begin
      state <= S_IDLE;
      len_hi <= '0;
      len <= '0;
      bus.wr_addr <= '0;
      word_cnt <= '0;
      err <= 1'b0;
      cpu_rst_f <= 1'b0;
    end else case (state)
      S_IDLE: if (start) begin
        state <= S_LEN_HI;
        bus.wr_addr <= '0;
        word_cnt <= '0;
        err <= 1'b0;
        cpu_rst_f <= 1'b0;
      end
      S_LEN_HI: if (acc) begin
        len_hi <= bus.rx_data;
        state <= S_LEN_LO;
      end
      S_LEN_LO: if (acc) begin
        len <= n_rx;
        err <= 32'(n_rx) > DEPTH;
        state <= 32'(n_rx) > DEPTH ? S_IDLE : n_rx == 16'd0 ? S_END : S_DATA;
      end
      S_DATA: if (last) state <= S_WRITE;
      S_WRITE: begin
        bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
        word_cnt <= word_cnt + (ADDR_W+1)'(1);
        state <= 32'(word_cnt) + 1 < 32'(len) ? S_DATA : S_END;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: if (acc) begin
        err <= bus.rx_data != csum;
        state <= bus.rx_data == csum ? S_DONE : S_IDLE;
      end
`endif
      S_DONE: begin
        cpu_rst_f <= 1'b1;
        state <= S_IDLE;
      end
      default: state <= S_IDLE;
    endcase
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: table-driven, hand-written and randomized load sessions against a stream model
module tb_im_loader;
  localparam int ADDR_W = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_f = 1'b1;
  logic start = 1'b0;
  logic cpu_rst_f, busy, done, err;
  logic [ADDR_W:0] word_cnt;
  int checks = 0;
  int fails = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  logic wr_rdy[$];
  int done_n = 0;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_f(rst_f),
    .start(start),
    .bus(bus),
    .cpu_rst_f(cpu_rst_f),
    .busy(busy),
    .done(done),
    .err(err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
      wr_rdy.push_back(bus.rx_ready);
    end
    if (done) done_n++;
  end

  typedef struct {
    int n;
    logic [31:0] w0;
    logic [31:0] w1;
    int gap;
    bit bad;
    bit ok;
    int nwr;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int t;
    bus.rx_valid = 1'b0;
    repeat (gaps) @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    t = 0;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rx_ready timeout", 0, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run(input string nm, input int n, input logic [31:0] w[$], input int gap,
                     input bit bad, input bit ok, input int nwr);
    logic [7:0] s[$];
    logic [7:0] ck;
    int base, d0, t;
    base = wa.size();
    d0 = done_n;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n <= DEPTH)
      for (int i = 0; i < n; i++)
        for (int k = 3; k >= 0; k--) s.push_back(w[i][8*k+:8]);
    ck = '0;
    foreach (s[i]) ck ^= s[i];
`ifdef IM_LOADER_CHECKSUM_EN
    if (n <= DEPTH) s.push_back(bad ? ~ck : ck);
`endif
    pulse_start();
    foreach (s[i]) send_byte(s[i], gap == 2 ? int'($urandom_range(0, 2)) : gap);
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({nm, " reaches idle"}, 64'(t < 40), 1);
    check({nm, " write count"}, wa.size() - base, nwr);
    for (int i = 0; i < nwr && base + i < wa.size(); i++) begin
      check({nm, " wr_addr"}, wa[base+i], i);
      check({nm, " wr_data"}, wd[base+i], w[i]);
      check({nm, " rx_ready in write"}, wr_rdy[base+i], 0);
    end
    check({nm, " done pulses"}, done_n - d0, ok);
    check({nm, " err"}, err, !ok);
    check({nm, " cpu_rst_f"}, cpu_rst_f, ok);
    check({nm, " word_cnt"}, word_cnt, n <= DEPTH ? n : 0);
    check({nm, " busy"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " rx_ready"}, bus.rx_ready, 0);
    check({nm, " wr_en"}, bus.wr_en, 0);
    check({nm, " wr_addr"}, bus.wr_addr, 0);
    check({nm, " wr_data"}, bus.wr_data, 0);
    check({nm, " word_cnt"}, word_cnt, 0);
    check({nm, " busy"}, busy, 0);
    check({nm, " done"}, done, 0);
    check({nm, " err"}, err, 0);
    check({nm, " cpu_rst_f"}, cpu_rst_f, 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] w[$];
    logic [7:0] seq[$];
    int base, d0, n;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    tbl[0] = '{2, 32'h11223344, 32'hA5B6C7D8, 0, 1'b0, 1'b1, 2};
    tbl[1] = '{2, 32'h11223344, 32'hA5B6C7D8, 1, 1'b0, 1'b1, 2};
    tbl[2] = '{0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 0};
    tbl[3] = '{5, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0};
    tbl[4] = '{1, 32'hDEADBEEF, 32'h0, 2, 1'b0, 1'b1, 1};
`ifdef IM_LOADER_CHECKSUM_EN
    tbl[5] = '{1, 32'hDEADBEEF, 32'h0, 0, 1'b1, 1'b0, 1};
`else
    tbl[5] = '{65535, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0};
`endif
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_f = 1'b0;
    @(negedge clk);
    check_reset_outputs("post-reset idle");

    foreach (tbl[v]) begin
      w = {};
      for (int i = 0; i < tbl[v].n && i < 2; i++) w.push_back(i == 0 ? tbl[v].w0 : tbl[v].w1);
      run($sformatf("vec%0d", v), tbl[v].n, w, tbl[v].gap, tbl[v].bad, tbl[v].ok, tbl[v].nwr);
    end

    // empty image: done right after the length (or trailing checksum) byte
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check("n0 done pulse", done, 1);
    @(negedge clk);
    check("n0 done one cycle", done, 0);
    check("n0 cpu_rst_f", cpu_rst_f, 1);
    check("n0 busy", busy, 0);

    // reset in the middle of a word abandons the session
    base = wa.size();
    pulse_start();
    seq = {8'h00, 8'h02, 8'h11, 8'h22};
    foreach (seq[i]) send_byte(seq[i], 0);
    rst_f = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    check("mid reset no write", wa.size() - base, 0);
    w = {32'h11223344, 32'hA5B6C7D8};
    run("after reset", 2, w, 0, 1'b0, 1'b1, 2);

    // start inside a session must be ignored
    base = wa.size();
    d0 = done_n;
    pulse_start();
    seq = {8'h00, 8'h01, 8'hDE};
    foreach (seq[i]) send_byte(seq[i], 0);
    pulse_start();
    seq = {8'hAD, 8'hBE, 8'hEF};
`ifdef IM_LOADER_CHECKSUM_EN
    seq.push_back(8'h23);
`endif
    foreach (seq[i]) send_byte(seq[i], 0);
    repeat (4) @(negedge clk);
    check("start ignored writes", wa.size() - base, 1);
    if (wa.size() > base) check("start ignored data", wd[base], 32'hDEADBEEF);
    check("start ignored done", done_n - d0, 1);
    check("start ignored err", err, 0);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 6);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run($sformatf("rand%0d", r), n, w, 2, 1'b0, n <= DEPTH, n <= DEPTH ? n : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
